// File: rtl/la_sdcmd.sv
// SD card CMD-line engine: serialises a 48-bit command frame with CRC7 on sd_tick,
// then waits for and deserialises a 48/136-bit response with timeout and end/CRC checks.
module la_sdcmd #(
  parameter string TARGET  = "DEFAULT",
  parameter int    TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         sd_tick,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   cmd_rtype,
  output logic         resp_valid,
  output logic [5:0]   resp_index,
  output logic [127:0] resp_data,
  output logic         resp_crc_err,
  output logic         resp_timeout,
  input  logic         sd_cmd_in,
  output logic         sd_cmd_out,
  output logic         sd_cmd_oe
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_e;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  // TARGET is reserved for technology-specific cell mapping; no logic depends on it.
  if (TARGET == "") begin : g_no_target
  end

  state_e         state_q, state_d;
  logic [47:0]    frame_q, frame_d;
  logic [1:0]     rtype_q, rtype_d;
  logic [9:0]     cnt_q, cnt_d;
  logic [126:0]   rx_q, rx_d;
  logic           rvalid_q, rvalid_d;
  logic [5:0]     ridx_q, ridx_d;
  logic [127:0]   rdata_q, rdata_d;
  logic           rcrc_q, rcrc_d;
  logic           rto_q, rto_d;

  logic [39:0]    tx_body;
  logic [46:0]    rx47;
  logic [127:0]   rx128;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    return c;
  endfunction

  assign tx_body = {2'b01, cmd_index, cmd_arg};
  // Views of the received frame including the bit arriving on this tick (start bit excluded).
  assign rx47    = {rx_q[45:0], sd_cmd_in};
  assign rx128   = {rx_q, sd_cmd_in};

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    rtype_d  = rtype_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    rvalid_d = 1'b0;
    ridx_d   = ridx_q;
    rdata_d  = rdata_q;
    rcrc_d   = rcrc_q;
    rto_d    = rto_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          frame_d = {tx_body, crc7(tx_body), 1'b1};
          rtype_d = cmd_rtype;
          cnt_d   = 10'd47;
          state_d = SEND;
        end
      end
      SEND: begin
        if (sd_tick) begin
          frame_d = {frame_q[46:0], 1'b1};
          if (cnt_q == 10'd0) begin
            if (rtype_q == 2'd0) begin
              state_d  = GAP;
              rvalid_d = 1'b1;
              ridx_d   = '0;
              rdata_d  = '0;
              rcrc_d   = 1'b0;
              rto_d    = 1'b0;
            end else begin
              state_d = WAIT;
            end
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
      end
      WAIT: begin
        if (sd_tick) begin
          if (!sd_cmd_in) begin
            state_d = RECV;
            cnt_d   = (rtype_q == 2'd2) ? 10'd134 : 10'd46;
          end else if (cnt_q == TO_LAST) begin
            state_d  = GAP;
            cnt_d    = '0;
            rvalid_d = 1'b1;
            ridx_d   = '0;
            rdata_d  = '0;
            rcrc_d   = 1'b0;
            rto_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      RECV: begin
        if (sd_tick) begin
          rx_d = {rx_q[125:0], sd_cmd_in};
          if (cnt_q == 10'd0) begin
            state_d  = GAP;
            rvalid_d = 1'b1;
            rto_d    = 1'b0;
            if (rtype_q == 2'd2) begin
              ridx_d  = '0;
              rdata_d = rx128;
              rcrc_d  = ~sd_cmd_in;
            end else begin
              // Leading start bit is 0, so it is re-inserted for the 40-bit CRC span.
              ridx_d  = rx47[45:40];
              rdata_d = {96'b0, rx47[39:8]};
              rcrc_d  = ~rx47[0] |
                        ((rtype_q == 2'd1) && (rx47[7:1] != crc7({1'b0, rx47[46:8]})));
            end
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
      end
      GAP: begin
        if (sd_tick) begin
          if (cnt_q == 10'd7) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= IDLE;
      frame_q  <= '1;
      rtype_q  <= '0;
      cnt_q    <= '0;
      rx_q     <= '0;
      rvalid_q <= 1'b0;
      ridx_q   <= '0;
      rdata_q  <= '0;
      rcrc_q   <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      rtype_q  <= rtype_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      rvalid_q <= rvalid_d;
      ridx_q   <= ridx_d;
      rdata_q  <= rdata_d;
      rcrc_q   <= rcrc_d;
      rto_q    <= rto_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign sd_cmd_oe    = (state_q == SEND);
  assign sd_cmd_out   = sd_cmd_oe ? frame_q[47] : 1'b1;
  assign resp_valid   = rvalid_q;
  assign resp_index   = ridx_q;
  assign resp_data    = rdata_q;
  assign resp_crc_err = rcrc_q;
  assign resp_timeout = rto_q;

endmodule

// File: tb/tb_la_sdcmd.sv
// Bench for la_sdcmd: transaction-level reference model compared every cycle,
// scripted card responder, directed cases plus randomized commands.
module tb_la_sdcmd;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         sd_tick = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   cmd_rtype = '0;
  logic         sd_cmd_in = 1'b1;
  logic         cmd_ready, resp_valid, resp_crc_err, resp_timeout, sd_cmd_out, sd_cmd_oe;
  logic [5:0]   resp_index;
  logic [127:0] resp_data;

  int n_checks = 0, n_errors = 0;
  int tick_pct = 50;
  logic ticked = 1'b0;

  always #5 clk = ~clk;

  la_sdcmd #(.TARGET("DEFAULT"), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nreset(nreset), .sd_tick(sd_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_rtype(cmd_rtype),
    .resp_valid(resp_valid), .resp_index(resp_index), .resp_data(resp_data),
    .resp_crc_err(resp_crc_err), .resp_timeout(resp_timeout),
    .sd_cmd_in(sd_cmd_in), .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe)
  );

  // CRC7 as polynomial long division of d * x^7 by x^7+x^3+1 (0x89).
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] m;
    m = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m = m ^ (47'h89 << (i - 7));
    return m[6:0];
  endfunction

  function automatic logic [47:0] mk48(input logic [5:0] idx, input logic [31:0] arg,
                                       input logic [6:0] crc_flip, input logic endb);
    return {2'b00, idx, arg, ref_crc7({2'b00, idx, arg}) ^ crc_flip, endb};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  logic         model_ok = 1'b0;
  logic         exp_ready, exp_oe, exp_out, exp_valid, exp_crc, exp_to;
  logic [5:0]   exp_idx;
  logic [127:0] exp_data;
  logic         m_rst, m_cvalid, m_tick, m_in;
  logic [5:0]   m_idx;
  logic [31:0]  m_arg;
  logic [1:0]   m_rtype;
  logic [47:0]  m_fr;
  logic [1:0]   m_rt;
  logic [135:0] m_w;
  logic         m_q[$];
  int           m_waited, m_gap;
  logic         m_got;

  task automatic m_edge();
    @(posedge clk);
    m_rst = !nreset; m_cvalid = cmd_valid; m_tick = sd_tick; m_in = sd_cmd_in;
    m_idx = cmd_index; m_arg = cmd_arg; m_rtype = cmd_rtype;
  endtask

  task automatic reset_exp();
    exp_ready = 1; exp_oe = 0; exp_out = 1; exp_valid = 0;
    exp_idx = '0; exp_data = '0; exp_crc = 0; exp_to = 0;
    model_ok = 1;
  endtask

  task automatic post(input logic [5:0] i, input logic [127:0] d, input logic c, input logic t);
    exp_valid = 1; exp_idx = i; exp_data = d; exp_crc = c; exp_to = t;
  endtask

  initial begin : model
    forever begin
      exp_ready = 1; exp_oe = 0; exp_out = 1;
      m_edge();
      if (m_rst) begin reset_exp(); continue; end
      exp_valid = 0;
      if (!m_cvalid) continue;
      m_fr = {2'b01, m_idx, m_arg, ref_crc7({2'b01, m_idx, m_arg}), 1'b1};
      m_rt = m_rtype;
      exp_ready = 0;
      for (int b = 47; b >= 0 && !m_rst; b--) begin
        exp_oe = 1; exp_out = m_fr[b];
        do m_edge(); while (!m_tick && !m_rst);
      end
      if (m_rst) begin reset_exp(); continue; end
      exp_oe = 0; exp_out = 1;
      if (m_rt == 2'd0) post('0, '0, 0, 0);
      else begin
        m_waited = 0; m_got = 0;
        while (!m_got && m_waited < TIMEOUT) begin
          m_edge();
          if (m_rst) break;
          if (m_tick) begin
            if (!m_in) m_got = 1;
            else m_waited++;
          end
        end
        if (m_rst) begin reset_exp(); continue; end
        if (!m_got) post('0, '0, 0, 1);
        else begin
          m_q.delete();
          while (m_q.size() < ((m_rt == 2'd2) ? 135 : 47)) begin
            m_edge();
            if (m_rst) break;
            if (m_tick) m_q.push_back(m_in);
          end
          if (m_rst) begin reset_exp(); continue; end
          m_w = '0;
          foreach (m_q[i]) m_w = {m_w[134:0], m_q[i]};
          if (m_rt == 2'd2) post('0, m_w[127:0], !m_w[0], 0);
          else post(m_w[45:40], {96'b0, m_w[39:8]},
                    !m_w[0] || (m_rt == 2'd1 && m_w[7:1] != ref_crc7({1'b0, m_w[46:8]})), 0);
        end
      end
      m_gap = 0;
      while (m_gap < 8) begin
        m_edge();
        if (m_rst) break;
        exp_valid = 0;
        if (m_tick) m_gap++;
      end
      if (m_rst) reset_exp();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("cmd_ready", 128'(cmd_ready), 128'(exp_ready));
      chk("sd_cmd_oe", 128'(sd_cmd_oe), 128'(exp_oe));
      chk("sd_cmd_out", 128'(sd_cmd_out), 128'(exp_out));
      chk("resp_valid", 128'(resp_valid), 128'(exp_valid));
      chk("resp_index", 128'(resp_index), 128'(exp_idx));
      chk("resp_data", resp_data, exp_data);
      chk("resp_crc_err", 128'(resp_crc_err), 128'(exp_crc));
      chk("resp_timeout", 128'(resp_timeout), 128'(exp_to));
    end
  end

  // ---------------- monitors for literal checks ----------------
  logic [47:0]  tx_sh = '0;
  int           tx_total = 0, n_resp = 0;
  logic [5:0]   l_idx;
  logic [127:0] l_data;
  logic         l_crc, l_to;

  initial forever begin
    @(negedge clk);
    if (nreset && sd_tick && sd_cmd_oe) begin
      tx_sh = {tx_sh[46:0], sd_cmd_out};
      tx_total++;
    end
    if (resp_valid) begin
      l_idx = resp_index; l_data = resp_data; l_crc = resp_crc_err; l_to = resp_timeout;
      n_resp++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    logic t;
    t = sd_tick;
    @(posedge clk); #1;
    ticked  = t;
    sd_tick = ($urandom_range(1, 100) <= tick_pct);
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin nxt(); if (ticked) k++; end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cmd_ready && k < 5000) begin nxt(); k++; end
    if (!cmd_ready) bound_fail("wait_ready");
  endtask

  task automatic accept(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    wait_ready();
    cmd_valid = 1; cmd_index = idx; cmd_arg = arg; cmd_rtype = rt;
    if ($urandom_range(0, 1) == 1) sd_tick = 1;
    nxt();
    // stray requests while busy must be ignored
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1; cmd_index = 6'($urandom); cmd_arg = $urandom; cmd_rtype = 2'($urandom);
      nxt();
    end
    cmd_valid = 0;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input int delay, input logic [135:0] rsp, input int nbits);
    int k;
    accept(idx, arg, rt);
    k = 0;
    while (sd_cmd_oe && k < 3000) begin nxt(); k++; end
    if (sd_cmd_oe) bound_fail("send_end");
    if (rt != 2'd0 && delay < TIMEOUT) begin
      wait_ticks(delay);
      for (int i = nbits - 1; i >= 0; i--) begin sd_cmd_in = rsp[i]; wait_ticks(1); end
      sd_cmd_in = 1;
    end
    wait_ready();
  endtask

  initial begin : stim
    int t0, r0, k;
    logic [135:0] r;
    logic [1:0]   rt;
    logic [5:0]   idx;
    logic [31:0]  arg;

    chk("model_crc_cmd0", 128'(ref_crc7(40'h4000000000)), 128'h4A);
    chk("model_crc_cmd8", 128'(ref_crc7(40'h48000001AA)), 128'h43);
    chk("model_crc_r7", 128'(ref_crc7(40'h08000001AA)), 128'h09);

    repeat (4) nxt();
    nreset = 1;
    nxt();
    chk("rst_ready", 128'(cmd_ready), 128'h1);
    chk("rst_oe", 128'(sd_cmd_oe), 128'h0);
    chk("rst_out", 128'(sd_cmd_out), 128'h1);
    chk("rst_data", resp_data, 128'h0);

    // CMD0, no response
    t0 = tx_total; r0 = n_resp;
    run_cmd(6'd0, 32'h0, 2'd0, 0, '0, 0);
    chk("cmd0_frame", 128'(tx_sh), 128'h400000000095);
    chk("cmd0_ticks", 128'(tx_total - t0), 128'd48);
    chk("cmd0_nresp", 128'(n_resp - r0), 128'd1);
    chk("cmd0_err", 128'({l_crc, l_to}), 128'h0);

    // CMD8 with R7 after 5 ticks
    run_cmd(6'd8, 32'h1AA, 2'd1, 5, 136'h08000001AA13, 48);
    chk("cmd8_frame", 128'(tx_sh), 128'h48000001AA87);
    chk("cmd8_idx", 128'(l_idx), 128'd8);
    chk("cmd8_data", l_data, 128'h1AA);
    chk("cmd8_crc", 128'(l_crc), 128'h0);

    run_cmd(6'd8, 32'h1AA, 2'd1, 5, 136'h08000001AA15, 48);
    chk("cmd8_badcrc", 128'(l_crc), 128'h1);
    run_cmd(6'd8, 32'h1AA, 2'd3, 5, 136'h08000001AA15, 48);
    chk("r3_nocrc", 128'(l_crc), 128'h0);

    // timeout and its boundary
    run_cmd(6'd55, 32'h0, 2'd1, TIMEOUT, '0, 0);
    chk("timeout_flag", 128'(l_to), 128'h1);
    run_cmd(6'd8, 32'h1AA, 2'd1, TIMEOUT - 1, 136'h08000001AA13, 48);
    chk("late_start_to", 128'(l_to), 128'h0);
    chk("late_start_idx", 128'(l_idx), 128'd8);
    run_cmd(6'd8, 32'h1AA, 2'd1, 0, 136'h08000001AA13, 48);
    chk("zero_delay_crc", 128'(l_crc), 128'h0);

    // R2
    r = {2'b00, 6'h3F, {16{8'hA5}}};
    run_cmd(6'd2, 32'h0, 2'd2, 3, r, 136);
    chk("r2_data", l_data, {16{8'hA5}});
    chk("r2_crc", 128'(l_crc), 128'h0);
    r[0] = 1'b0;
    run_cmd(6'd2, 32'h0, 2'd2, 3, r, 136);
    chk("r2_endbit", 128'(l_crc), 128'h1);

    // reset while sending bit 20, then a clean command
    t0 = tx_total;
    accept(6'd17, 32'hDEADBEEF, 2'd1);
    k = 0;
    while (tx_total - t0 < 27 && k < 3000) begin nxt(); k++; end
    if (tx_total - t0 < 27) bound_fail("mid_send");
    nreset = 0;
    nxt();
    nreset = 1;
    chk("midrst_oe", 128'(sd_cmd_oe), 128'h0);
    chk("midrst_out", 128'(sd_cmd_out), 128'h1);
    chk("midrst_ready", 128'(cmd_ready), 128'h1);
    t0 = tx_total;
    run_cmd(6'd0, 32'h0, 2'd0, 0, '0, 0);
    chk("post_rst_frame", 128'(tx_sh), 128'h400000000095);
    chk("post_rst_ticks", 128'(tx_total - t0), 128'd48);

    // randomized commands
    for (int t = 0; t < 24; t++) begin
      tick_pct = $urandom_range(30, 100);
      rt  = 2'($urandom);
      idx = 6'($urandom);
      arg = $urandom;
      k   = $urandom_range(0, TIMEOUT + 4);
      if (rt == 2'd2) begin
        r = {2'b00, 6'h3F, $urandom, $urandom, $urandom, $urandom};
        r[0] = ($urandom_range(0, 4) != 0);
        run_cmd(idx, arg, rt, k, r, 136);
      end else begin
        r = {88'b0, mk48(idx, $urandom,
                         ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'h0,
                         ($urandom_range(0, 5) != 0))};
        run_cmd(idx, arg, rt, k, r, 48);
      end
    end

    repeat (3) nxt();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/la_sdcmd.md
LA_SDCMD -- requirements
Module: la_sdcmd

Interface
REQ-001 Parameter TARGET, default "DEFAULT": technology target string, passed through, no functional effect.
REQ-002 Parameter TIMEOUT, default 64: maximum SD-clock ticks to wait for a response start bit (NCR); legal range 2..1023.
REQ-003 clk  input  1: core clock; single clock domain, all logic rising-edge.
REQ-004 nreset  input  1: reset, synchronous, active-low.
REQ-005 sd_tick  input  1: one-cycle pulse marking each SD clock edge; all line activity advances only on sd_tick.
REQ-006 cmd_valid  input  1: command request valid.
REQ-007 cmd_ready  output  1: command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_index  input  6: command index.
REQ-009 cmd_arg  input  32: command argument.
REQ-010 cmd_rtype  input  2: response type; 0 none, 1 48-bit, 2 136-bit (R2), 3 48-bit without CRC check (R3).
REQ-011 resp_valid  output  1: one-cycle pulse, command/response transaction complete.
REQ-012 resp_index  output  6: received index field (48-bit types), else 0.
REQ-013 resp_data  output  128: 48-bit types: [31:0] = argument field, rest 0; R2: frame bits [127:0], bit 0 = end bit.
REQ-014 resp_crc_err  output  1: CRC7 or end-bit error, valid with resp_valid.
REQ-015 resp_timeout  output  1: no start bit within TIMEOUT ticks, valid with resp_valid.
REQ-016 sd_cmd_in  input  1: CMD line sampled value.
REQ-017 sd_cmd_out  output  1: CMD line drive value.
REQ-018 sd_cmd_oe  output  1: CMD line output enable.

Function
REQ-019 FSM states: IDLE, SEND, WAIT, RECV, GAP; cmd_ready = 1 only in IDLE.
REQ-020 On acceptance, the block SHALL latch index/arg/rtype and enter SEND next cycle with sd_cmd_oe=1, sd_cmd_out = frame bit 47.
REQ-021 SEND frame, MSB first: start 0, transmit 1, index[5:0], arg[31:0], CRC7[6:0], end 1 (48 bits).
REQ-022 CRC7: polynomial x^7+x^3+1, init 0, over the first 40 frame bits; computed serially or precomputed, same result.
REQ-023 In SEND, each sd_tick advances to the next bit; the tick that completes bit 0 exits SEND: to GAP if rtype=0, else to WAIT, with sd_cmd_oe=0 from the next cycle.
REQ-024 sd_cmd_out SHALL be 1 whenever sd_cmd_oe=0.
REQ-025 WAIT: on each sd_tick, sd_cmd_in=0 -> RECV (start bit consumed); else increment tick counter; counter reaching TIMEOUT -> assert resp_valid with resp_timeout=1 and enter GAP.
REQ-026 RECV: shift sd_cmd_in on each sd_tick; 47 more bits for rtype 1/3, 135 for rtype 2.
REQ-027 Response checks: rtype 1: CRC7 over bits 47..8 must equal bits 7..1; rtype 1/2/3: end bit must be 1; any mismatch sets resp_crc_err; rtype 2/3 skip CRC; transmit bit not checked.
REQ-028 On the last RECV tick, resp_valid SHALL pulse the following cycle with resp_index/resp_data/resp_crc_err updated; outputs hold until the next resp_valid.
REQ-029 For rtype=0, resp_valid SHALL pulse on SEND exit with errors=0, resp_data=0.
REQ-030 GAP: hold line released for 8 sd_ticks (NCC/NRC), then IDLE.
REQ-031 Input cmd_valid outside IDLE SHALL be ignored (no queueing); cmd fields must be held until accepted.
REQ-032 sd_tick coincident with acceptance cycle SHALL NOT advance the frame.

Reset
REQ-033 nreset low at a clk edge SHALL force IDLE, cmd_ready=1 after release, sd_cmd_oe=0, sd_cmd_out=1, resp_valid=0, resp_index=0, resp_data=0, resp_crc_err=0, resp_timeout=0, counters 0, regardless of current state.

Verification
REQ-034 CMD0 arg 0x00000000, rtype 0 -> line carries 0x400000000095 MSB first, oe high 48 ticks, resp_valid with no errors, 8-tick GAP then cmd_ready.
REQ-035 CMD8 arg 0x000001AA, rtype 1, card returns 0x08000001AA13 after 5 ticks -> sent frame 0x48000001AA87; resp_index=8, resp_data[31:0]=0x000001AA, resp_crc_err=0.
REQ-036 Same as REQ-035 with response CRC byte corrupted to 0x15 -> resp_crc_err=1; with rtype 3 and same data -> resp_crc_err=0.
REQ-037 rtype 1, sd_cmd_in held 1 -> resp_valid exactly after TIMEOUT (64) WAIT ticks with resp_timeout=1, then GAP.
REQ-038 R2 with 136-bit frame of pattern 0x3F + 128-bit 0xA5.. ending in 1 -> resp_data matches bits 127:0, resp_crc_err=0.
REQ-039 nreset asserted mid-SEND at bit 20 -> next cycle oe=0, out=1, IDLE; new command then sends full 48-bit frame correctly.
